// File: rtl/fetch_sequencer.sv
// PC sequencer and bundle buffer feeding instruction fetch: issues bundle reads,
// tags in-order responses with their PC and flushes stale work on redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned BUNDLE_BYTES = 16,
  parameter int unsigned BUF_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [127:0] imem_resp_bundle,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         bundle_valid,
  input  logic         bundle_ready,
  output logic [31:0]  bundle_pc,
  output logic [127:0] bundle_data,
  output logic         busy
);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] buf_head_q, buf_head_d, buf_tail_q, buf_tail_d;
  logic [PW-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;

  logic [31:0]   buf_pc_q   [BUF_DEPTH];
  logic [127:0]  buf_data_q [BUF_DEPTH];
  logic [31:0]   tag_pc_q   [BUF_DEPTH];

  logic          redirect_take, req_fire, pop, resp_push, resp_hit;
  logic [CW:0]   in_flight;
  logic [CW-1:0] pending;

  // Redirects are only honoured once the sequencer has left BOOT.
  assign redirect_take  = redirect_valid && (state_q != BOOT);
  assign in_flight      = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == RUN) && (in_flight < DEPTH_W) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign bundle_valid   = (count_q != '0);
  assign pop            = bundle_valid && bundle_ready;
  assign bundle_pc      = bundle_valid ? buf_pc_q[buf_head_q]   : '0;
  assign bundle_data    = bundle_valid ? buf_data_q[buf_head_q] : '0;
  assign busy           = (state_q != RUN) || (outstanding_q != '0);

  assign resp_push = (state_q == RUN) && !redirect_take && imem_resp_valid &&
                     (outstanding_q != '0);
  // Outstanding is zero in FLUSH and drop_cnt is zero in RUN, so the sum is
  // the number of responses still owed by memory.
  assign pending   = outstanding_q + drop_cnt_q;
  assign resp_hit  = imem_resp_valid && (pending != '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    buf_head_d    = buf_head_q;
    buf_tail_d    = buf_tail_q;
    tag_head_d    = tag_head_q;
    tag_tail_d    = tag_tail_q;

    if (redirect_take) begin
      fetch_pc_d    = redirect_pc;
      count_d       = '0;
      outstanding_d = '0;
      buf_head_d    = '0;
      buf_tail_d    = '0;
      tag_head_d    = '0;
      tag_tail_d    = '0;
      drop_cnt_d    = pending - CW'(resp_hit);
      state_d       = (drop_cnt_d != '0) ? FLUSH : RUN;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'(BUNDLE_BYTES);
        tag_tail_d = tag_tail_q + 1'b1;
      end
      if (resp_push) begin
        buf_tail_d = buf_tail_q + 1'b1;
        tag_head_d = tag_head_q + 1'b1;
      end
      if (pop) buf_head_d = buf_head_q + 1'b1;
      count_d       = count_q + CW'(resp_push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_push);

      unique case (state_q)
        BOOT:  state_d = RUN;
        FLUSH: begin
          if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
            if (drop_cnt_q == CW'(1)) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      buf_head_q    <= '0;
      buf_tail_q    <= '0;
      tag_head_q    <= '0;
      tag_tail_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      buf_head_q    <= buf_head_d;
      buf_tail_q    <= buf_tail_d;
      tag_head_q    <= tag_head_d;
      tag_tail_q    <= tag_tail_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (req_fire) tag_pc_q[tag_tail_q] <= fetch_pc_q;
    if (resp_push) begin
      buf_pc_q[buf_tail_q]   <= tag_pc_q[tag_head_q];
      buf_data_q[buf_tail_q] <= imem_resp_bundle;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: an in-order memory model
// with variable latency, a PC-stream reference model and a decoupled monitor.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 4;

  logic         clk, rst;
  logic         imem_req_valid, imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [127:0] imem_resp_bundle;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         bundle_valid, bundle_ready;
  logic [31:0]  bundle_pc;
  logic [127:0] bundle_data;
  logic         busy;

  fetch_sequencer #(.RESET_PC(RESET_PC), .BUNDLE_BYTES(16), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_bundle(imem_resp_bundle),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .bundle_pc(bundle_pc), .bundle_data(bundle_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Contents of memory at any bundle address.
  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_A5A5, ~a, a + 32'h1234_5678, a};
  endfunction

  // ---------------- memory model: in order, latency lat_min..lat_max ----------------
  typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
  mreq_t       mem_q[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;

  initial begin
    imem_resp_valid  = 1'b0;
    imem_resp_bundle = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        imem_resp_valid  = 1'b1;
        imem_resp_bundle = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_resp_valid  = 1'b0;
        imem_resp_bundle = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        mreq_t m;
        m.due  = cyc + $urandom_range(lat_max, lat_min);
        if (mem_q.size() > 0 && m.due <= mem_q[$].due) m.due = mem_q[$].due + 1;
        m.addr = imem_req_addr;
        mem_q.push_back(m);
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  // Every request issued since the last redirect/reset must come back to the
  // consumer in order, tagged with its own address; anything older is dropped.
  typedef struct { logic [31:0] pc; logic [127:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] req_next = RESET_PC;
  int          fire_count = 0, pop_count = 0;
  logic [31:0] last_fire_addr = '0, last_pop_pc = '0;
  logic        mon_rst_prev = 1'b0, req_stall_prev = 1'b0, bun_stall_prev = 1'b0;
  logic [31:0] prev_req_addr, prev_bun_pc;
  logic [127:0] prev_bun_data;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_rst_prev) begin
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_bundle_valid", bundle_valid, 1'b0);
        check("rst_bundle_pc", bundle_pc, 32'h0);
        check("rst_bundle_data", bundle_data, 128'h0);
        check("rst_busy", busy, 1'b1);
      end
      if (rst) begin
        exp_q.delete();
        req_next       = RESET_PC;
        mon_rst_prev   = 1'b1;
        req_stall_prev = 1'b0;
        bun_stall_prev = 1'b0;
      end else begin
        logic boot;
        boot         = mon_rst_prev;
        mon_rst_prev = 1'b0;
        if (req_stall_prev && !redirect_valid) begin
          check("req_hold_valid", imem_req_valid, 1'b1);
          check("req_hold_addr", imem_req_addr, prev_req_addr);
        end
        if (bun_stall_prev) begin
          check("bundle_hold_valid", bundle_valid, 1'b1);
          check("bundle_hold_pc", bundle_pc, prev_bun_pc);
          check("bundle_hold_data", bundle_data, prev_bun_data);
        end
        if (redirect_valid) check("req_in_redirect", imem_req_valid, 1'b0);
        if (imem_req_valid) check("req_window", exp_q.size() < BUF_DEPTH, 1'b1);
        if (imem_req_valid && imem_req_ready) begin
          exp_t e;
          check("req_addr", imem_req_addr, req_next);
          e.pc   = imem_req_addr;
          e.data = mem_word(imem_req_addr);
          exp_q.push_back(e);
          req_next       = req_next + 32'd16;
          last_fire_addr = imem_req_addr;
          fire_count++;
        end
        if (bundle_valid && bundle_ready) begin
          check("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("bundle_pc", bundle_pc, e.pc);
            check("bundle_data", bundle_data, e.data);
          end
          last_pop_pc = bundle_pc;
          pop_count++;
        end
        if (redirect_valid && !boot) begin
          exp_q.delete();
          req_next = redirect_pc;
        end
        req_stall_prev = imem_req_valid && !imem_req_ready;
        prev_req_addr  = imem_req_addr;
        bun_stall_prev = bundle_valid && !bundle_ready && !redirect_valid;
        prev_bun_pc    = bundle_pc;
        prev_bun_data  = bundle_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int target, input int budget);
    for (int i = 0; i < budget && fire_count < target; i++) step();
  endtask

  initial begin
    int f0, p0;
    rst = 1'b1; imem_req_ready = 1'b1; bundle_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    // 1: boot timing, sequential addresses, redirect ignored in BOOT, full throughput
    lat_min = 1; lat_max = 1;
    do_reset(4);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    repeat (8) step();
    p0 = pop_count;
    repeat (10) step();
    check("throughput", pop_count - p0, 10);

    // 2: consumer stalled -> exactly BUF_DEPTH requests, then resume at 0x40
    bundle_ready = 1'b0;
    do_reset(4);
    f0 = fire_count;
    repeat (12) step();
    @(negedge clk);
    check("bp_fires", fire_count - f0, BUF_DEPTH);
    check("bp_req_idle", imem_req_valid, 1'b0);
    check("bp_head_pc", bundle_pc, 32'h0);
    step();
    bundle_ready = 1'b1;
    wait_fires(f0 + 5, 20);
    check("bp_resume_addr", last_fire_addr, 32'h40);

    // 3: memory stalls for 3 cycles while 0x20 is pending
    do_reset(4);
    f0 = fire_count;
    wait_fires(f0 + 2, 20);
    check("hold_setup", fire_count - f0, 2);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", imem_req_valid, 1'b1);
      check("stall_addr", imem_req_addr, 32'h20);
      step();
    end
    imem_req_ready = 1'b1;
    wait_fires(f0 + 3, 10);
    check("stall_resume_addr", last_fire_addr, 32'h20);

    // 4: redirect with two in flight, one answering in the redirect cycle
    lat_min = 3; lat_max = 3;
    do_reset(4);
    step();                       // first RUN cycle: request 0x0
    step();                       // request 0x10
    step();
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    @(negedge clk);
    check("rd_no_req", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_buf_empty", bundle_valid, 1'b0);
    check("rd_flush_busy", busy, 1'b1);
    check("rd_flush_no_req", imem_req_valid, 1'b0);
    step();
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("rd_req_valid", imem_req_valid, 1'b1);
    check("rd_req_addr", imem_req_addr, 32'h0000_1000);
    p0 = pop_count;
    for (int i = 0; i < 30 && pop_count == p0; i++) step();
    check("rd_first_bundle", last_pop_pc, 32'h0000_1000);

    // 5: PC wraps modulo 2^32
    lat_min = 1; lat_max = 2;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFE0;
    step();
    redirect_valid = 1'b0;
    f0 = fire_count;
    wait_fires(f0 + 3, 40);
    check("wrap_addr", last_fire_addr, 32'h0000_0000);

    // 6: reset with three outstanding requests
    lat_min = 4; lat_max = 4;
    do_reset(4);
    f0 = fire_count;
    repeat (4) step();
    rst = 1'b1; imem_req_ready = 1'b0;
    check("rst_outstanding", fire_count - f0, 3);
    step();
    @(negedge clk);
    check("midrst_req_valid", imem_req_valid, 1'b0);
    check("midrst_bundle_valid", bundle_valid, 1'b0);
    check("midrst_busy", busy, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0; imem_req_ready = 1'b1;
    f0 = fire_count;
    wait_fires(f0 + 1, 10);
    check("restart_addr", last_fire_addr, RESET_PC);

    // random traffic with redirects and the occasional reset
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      imem_req_ready = ($urandom_range(99) < 75);
      bundle_ready   = ($urandom_range(99) < ((i < 1500) ? 85 : 40));
      if (redirect_valid) redirect_valid = 1'b0;
      else if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FF80 + 32'($urandom_range(7)) * 16)
                                                  : ($urandom & 32'hFFFF_FFF0);
      end
      if ($urandom_range(999) == 0) do_reset(10);
    end

    // drain: no new requests, everything owed must surface and match
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b0; bundle_ready = 1'b1;
    for (int i = 0; i < 200 && (busy || bundle_valid); i++) @(negedge clk);
    @(negedge clk);
    check("drain_idle", busy, 1'b0);
    check("drain_scoreboard", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
